// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, idle line level and parity helper.
// Reused by the RX stage later on.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    localparam logic UART_IDLE_LEVEL = 1'b1;
    localparam int   UART_MAX_WIDTH  = 32;

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic even_parity(input logic [UART_MAX_WIDTH-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the terminal count.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clock,
    input  logic resetn,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_bit_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_bit_tick = i_enable && (r_cnt == LAST_CNT);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= o_bit_tick ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_drain.sv
// UART transmit stage that drains the byte FIFO: pop, load, then shift out
// start / LSB-first data / optional even parity / stop bits. All outputs registered.
module uart_tx_drain
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  fifo_empty,
    output logic                  fifo_pop,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  tx,
    output logic                  busy
);

    localparam int BC_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [BC_W-1:0] LAST_BIT  = BC_W'(DATA_WIDTH - 1);
    localparam logic [BC_W-1:0] LAST_STOP = BC_W'(STOP_BITS - 1);

    uart_tx_state_t r_state, w_next;

    logic [DATA_WIDTH-1:0]     r_shift;
    logic                      r_parity;
    logic [BC_W-1:0]           r_bit_cnt;
    logic                      r_tx;
    logic                      r_pop;
    logic                      r_busy;
    logic [UART_MAX_WIDTH-1:0] w_par_in;

    logic w_tick, w_baud_en, w_baud_clr;
    logic w_tx_nxt, w_shift_ld, w_shift_en, w_cnt_clr, w_cnt_inc;

    assign w_baud_en  = (r_state == START) || (r_state == DATA) ||
                        (r_state == PARITY) || (r_state == STOP);
    assign w_baud_clr = (r_state == LOAD);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clock     (clock),
        .resetn    (resetn),
        .i_clear   (w_baud_clr),
        .i_enable  (w_baud_en),
        .o_bit_tick(w_tick)
    );

    always_comb begin
        w_par_in = '0;
        w_par_in[DATA_WIDTH-1:0] = fifo_data;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_next;
    end

    // tx is computed one state ahead so the line changes on the same edge as the state.
    always_comb begin
        w_next     = r_state;
        w_tx_nxt   = r_tx;
        w_shift_ld = 1'b0;
        w_shift_en = 1'b0;
        w_cnt_clr  = 1'b0;
        w_cnt_inc  = 1'b0;
        case (r_state)
            IDLE: if (!fifo_empty) w_next = POP;
            POP:  w_next = LOAD;
            LOAD: begin
                w_next     = START;
                w_shift_ld = 1'b1;
                w_cnt_clr  = 1'b1;
                w_tx_nxt   = 1'b0;
            end
            START: if (w_tick) begin
                w_next   = DATA;
                w_tx_nxt = r_shift[0];
            end
            DATA: if (w_tick) begin
                if (r_bit_cnt == LAST_BIT) begin
                    w_cnt_clr = 1'b1;
                    if (PARITY_EN != 0) begin
                        w_next   = PARITY;
                        w_tx_nxt = r_parity;
                    end else begin
                        w_next   = STOP;
                        w_tx_nxt = UART_IDLE_LEVEL;
                    end
                end else begin
                    w_shift_en = 1'b1;
                    w_cnt_inc  = 1'b1;
                    w_tx_nxt   = r_shift[1];
                end
            end
            PARITY: if (w_tick) begin
                w_next   = STOP;
                w_tx_nxt = UART_IDLE_LEVEL;
            end
            STOP: if (w_tick) begin
                // bit_cnt is reused to count stop bits
                if (r_bit_cnt != LAST_STOP) w_cnt_inc = 1'b1;
                else if (!fifo_empty)       w_next    = POP;
                else                        w_next    = IDLE;
            end
            default: begin
                w_next   = IDLE;
                w_tx_nxt = UART_IDLE_LEVEL;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_tx      <= UART_IDLE_LEVEL;
            r_pop     <= 1'b0;
            r_busy    <= 1'b0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_bit_cnt <= '0;
        end else begin
            r_tx   <= w_tx_nxt;
            r_pop  <= (w_next == POP);
            r_busy <= (w_next != IDLE);
            if (w_shift_ld) begin
                r_shift  <= fifo_data;
                r_parity <= even_parity(w_par_in);
            end else if (w_shift_en) begin
                r_shift <= r_shift >> 1;
            end
            if (w_cnt_clr)      r_bit_cnt <= '0;
            else if (w_cnt_inc) r_bit_cnt <= r_bit_cnt + 1'b1;
        end
    end

    assign tx       = r_tx;
    assign fifo_pop = r_pop;
    assign busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Scoreboard bench: two transmitters (8N1 and 8E2) fed from FIFO models, checked by
// line-level receivers against frames and pop timing derived from the word stream.
module tb_uart_tx_drain;

    localparam int CPB = 4;
    localparam int DW  = 8;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc = cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_lane
        localparam int PE   = (g == 1) ? 1 : 0;
        localparam int SB   = (g == 1) ? 2 : 1;
        localparam int FLEN = 1 + DW + PE + SB;

        logic          fifo_empty = 1'b1;
        logic          fifo_pop, tx, busy;
        logic [DW-1:0] fifo_data  = '0;
        logic          glitch     = 1'b0;
        logic [DW-1:0] q[$];
        logic [DW-1:0] exp_q[$];

        uart_tx_drain #(
            .DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(PE), .STOP_BITS(SB)
        ) dut (
            .clock(clock), .resetn(resetn), .fifo_empty(fifo_empty), .fifo_pop(fifo_pop),
            .fifo_data(fifo_data), .tx(tx), .busy(busy)
        );

        // FIFO model: word appears on fifo_data only in the cycle after the pop; garbage otherwise.
        logic [DW-1:0] held;
        bit            pend = 0;
        always @(posedge clock) begin
            #1;
            if (pend) begin
                fifo_data = held;
                pend      = 0;
            end else begin
                fifo_data = DW'($urandom);
            end
            if (fifo_pop === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL lane%0d pop_empty: fifo_pop=1 at cycle %0d, required 0 (FIFO empty)", g, cyc);
                end else begin
                    held = q.pop_front();
                    pend = 1;
                end
            end
            fifo_empty = (q.size() == 0) && !glitch;
        end

        // Receiver / scoreboard
        bit              in_frame = 0, ready = 1, busy_exp = 0;
        int              exp_pop = -1, pop_cyc = 0, fstart = 0, fbad = 0;
        int              busy_bad = 0, rst_bad = 0;
        logic [FLEN-1:0] ebits;
        logic [DW-1:0]   w;
        always @(negedge clock) begin
            if (!resetn) begin
                in_frame = 0; ready = 1; busy_exp = 0; exp_pop = -1;
                if (tx !== 1'b1 || busy !== 1'b0 || fifo_pop !== 1'b0) rst_bad++;
            end else begin
                if (fifo_pop === 1'b1) begin
                    checks++;
                    if (cyc != exp_pop) begin
                        errors++;
                        $display("FAIL lane%0d pop_time: pop at cycle %0d, required cycle %0d", g, cyc, exp_pop);
                    end
                    exp_pop = -1; busy_exp = 1; pop_cyc = cyc;
                end
                if (busy !== busy_exp) busy_bad++;
                if (in_frame) begin
                    if (tx !== ebits[(cyc - fstart) / CPB]) fbad++;
                    if (cyc - fstart == FLEN * CPB - 1) begin
                        checks++;
                        if (fbad != 0) begin
                            errors++;
                            $display("FAIL lane%0d frame: word %02h had %0d wrong tx cycles, required 0", g, w, fbad);
                        end
                        in_frame = 0; busy_exp = 0; ready = 1;
                    end
                end else if (tx !== 1'b1) begin
                    checks++;
                    in_frame = 1; fstart = cyc; fbad = 0;
                    if (exp_q.size() == 0 || !busy_exp) begin
                        errors++;
                        $display("FAIL lane%0d start: tx=%b at cycle %0d, required idle 1", g, tx, cyc);
                        w = '0; ebits = '1;
                    end else begin
                        w = exp_q.pop_front();
                        ebits = '1;
                        ebits[0] = 1'b0;
                        for (int i = 0; i < DW; i++) ebits[1 + i] = w[i];
                        if (PE == 1) ebits[1 + DW] = ^w;
                        checks++;
                        if (cyc != pop_cyc + 2) begin
                            errors++;
                            $display("FAIL lane%0d start_time: start at cycle %0d, required %0d", g, cyc, pop_cyc + 2);
                        end
                    end
                end
                if (ready && fifo_empty === 1'b0 && !busy_exp) begin
                    exp_pop = cyc + 1;
                    ready   = 0;
                end
                if (exp_pop >= 0 && cyc > exp_pop) begin
                    checks++; errors++;
                    $display("FAIL lane%0d missing_pop: no pop by cycle %0d, required at %0d", g, cyc, exp_pop);
                    exp_pop = -1;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] wd);
        g_lane[0].q.push_back(wd); g_lane[0].exp_q.push_back(wd);
        g_lane[1].q.push_back(wd); g_lane[1].exp_q.push_back(wd);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        bit done = 0;
        while (!done && n < budget) begin
            @(negedge clock); #1;
            n++;
            done = g_lane[0].exp_q.size() == 0 && g_lane[1].exp_q.size() == 0 &&
                   g_lane[0].q.size() == 0 && g_lane[1].q.size() == 0 &&
                   !g_lane[0].in_frame && !g_lane[1].in_frame &&
                   g_lane[0].busy === 1'b0 && g_lane[1].busy === 1'b0;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL drain_timeout: still busy after %0d cycles, required idle", budget);
        end
        repeat (3) @(posedge clock);
        #2;
    endtask

    // Returns at negedge+1 of the first start-bit cycle on lane 0.
    task automatic wait_start();
        int n = 0;
        bit seen = 0;
        while (!seen && n < 200) begin
            @(negedge clock); #1;
            n++;
            seen = g_lane[0].in_frame && (g_lane[0].fstart == cyc);
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL start_timeout: no start bit within 200 cycles, required one");
        end
    endtask

    initial begin
        // Reset held with empty FIFOs: line idle, no pops, not busy
        repeat (100) @(posedge clock);
        #2;
        chk("reset_tx0", int'(g_lane[0].tx), 1);
        chk("reset_busy1", int'(g_lane[1].busy), 0);
        resetn = 1'b1;
        repeat (20) @(posedge clock);
        #2;
        chk("idle_pop0", int'(g_lane[0].fifo_pop), 0);

        push_word(8'hA5);
        wait_idle(400);
        push_word(8'h07);
        wait_idle(400);

        // Back-to-back burst, including all-zero and all-one words
        push_word(8'h00); push_word(8'hFF); push_word(8'h3C);
        wait_idle(800);

        // Empty-flag glitch during lane 0 STOP must not trigger a pop
        push_word(8'h5A);
        wait_start();
        repeat (9 * CPB + 1) @(negedge clock);
        #2;
        g_lane[0].glitch = 1'b1; g_lane[1].glitch = 1'b1;
        @(negedge clock); #2;
        g_lane[0].glitch = 1'b0; g_lane[1].glitch = 1'b0;
        wait_idle(400);

        // Reset during data bit 3 (bit 3 of F0 is 0, so tx must rise on reset)
        push_word(8'hF0);
        wait_start();
        repeat (4 * CPB + 1) @(negedge clock);
        #2;
        resetn = 1'b0;
        #1;
        chk("midreset_tx0", int'(g_lane[0].tx), 1);
        chk("midreset_tx1", int'(g_lane[1].tx), 1);
        chk("midreset_busy0", int'(g_lane[0].busy), 0);
        push_word(8'h96);
        repeat (5) @(posedge clock);
        #2;
        resetn = 1'b1;
        wait_idle(400);

        for (int i = 0; i < 24; i++) begin
            push_word(DW'($urandom_range(0, 255)));
            if ($urandom_range(0, 2) == 0) wait_idle(600);
            else begin
                repeat ($urandom_range(0, 60)) @(posedge clock);
                #2;
            end
        end
        wait_idle(4000);

        chk("busy_lane0", g_lane[0].busy_bad, 0);
        chk("busy_lane1", g_lane[1].busy_bad, 0);
        chk("reset_lane0", g_lane[0].rst_bad, 0);
        chk("reset_lane1", g_lane[1].rst_bad, 0);
        chk("leftover_exp0", g_lane[0].exp_q.size(), 0);
        chk("leftover_exp1", g_lane[1].exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
